// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline constants and inter-stage bundles.
// Imported by every pipeline stage.
package riscv_pkg;

    localparam int          XLEN        = 32;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            misalign;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Priority: flush > stall > load.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] NOP = riscv_pkg::NOP_INSTR
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   flush_i,
    input  logic   stall_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    if_id_t q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q.valid    <= 1'b0;
            q.instr    <= NOP;
            q.pc       <= '0;
            q.pc_plus4 <= '0;
            q.misalign <= 1'b0;
        end else if (flush_i) begin
            // Bubble keeps the old PC fields for debug visibility
            q.valid    <= 1'b0;
            q.instr    <= NOP;
            q.misalign <= 1'b0;
        end else if (!stall_i) begin
            q <= d_i;
        end
    end

    assign q_o = q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection, IF/ID capture
// and valid-fetch counter.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR,
    parameter int          XLEN      = riscv_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_instr_i,
    output logic            if_id_valid_o,
    output logic [XLEN-1:0] if_id_instr_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_pc_plus4_o,
    output logic            if_id_misalign_o,
    output logic [XLEN-1:0] fetch_count_o
);

    import riscv_pkg::*;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4;
    logic            misalign_q;
    logic [XLEN-1:0] count_q;
    logic            kill;
    logic            capture;
    if_id_t          if_id_d;
    if_id_t          if_id_q;

    assign pc_plus4 = pc_q + INSTR_BYTES;
    assign kill     = redirect_i | flush_i;
    assign capture  = !kill && !stall_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else if (redirect_i) begin
            // Low bits are dropped; the fault is carried as a flag
            pc_q       <= {redirect_pc_i[XLEN-1:2], 2'b00};
            misalign_q <= |redirect_pc_i[1:0];
        end else if (!stall_i) begin
            pc_q       <= pc_plus4;
            misalign_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (capture) begin
            count_q <= count_q + 1'b1;
        end
    end

    always_comb begin
        if_id_d          = '0;
        if_id_d.valid    = 1'b1;
        if_id_d.instr    = imem_instr_i;
        if_id_d.pc       = pc_q;
        if_id_d.pc_plus4 = pc_plus4;
        if_id_d.misalign = misalign_q;
    end

    if_id_reg #(
        .NOP (NOP_INSTR)
    ) u_if_id (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (kill),
        .stall_i (stall_i),
        .d_i     (if_id_d),
        .q_o     (if_id_q)
    );

    assign imem_addr_o      = pc_q;
    assign if_id_valid_o    = if_id_q.valid;
    assign if_id_instr_o    = if_id_q.instr;
    assign if_id_pc_o       = if_id_q.pc;
    assign if_id_pc_plus4_o = if_id_q.pc_plus4;
    assign if_id_misalign_o = if_id_q.misalign;
    assign fetch_count_o    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational program
// image and a scoreboard of expected post-edge outputs.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        mis;
    logic [31:0] cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    // Bench-side model state
    logic [31:0] m_pc;
    logic        m_mis;
    exp_t        m;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h00:  return 32'h0050_0093;
            32'h04:  return 32'h00A0_8113;
            32'h14:  return 32'h0030_2023;
            32'h1C:  return 32'h0002_8C63;
            default: return a ^ 32'hDEAD_0000;
        endcase
    endfunction

    always_comb imem_instr = imem(imem_addr);

    fetch_stage dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .stall_i          (stall),
        .flush_i          (flush),
        .redirect_i       (redir),
        .redirect_pc_i    (redir_pc),
        .imem_addr_o      (imem_addr),
        .imem_instr_i     (imem_instr),
        .if_id_valid_o    (v),
        .if_id_instr_o    (instr),
        .if_id_pc_o       (pc),
        .if_id_pc_plus4_o (pc4),
        .if_id_misalign_o (mis),
        .fetch_count_o    (cnt)
    );

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_mis   = 1'b0;
        m.addr  = 32'h0;
        m.v     = 1'b0;
        m.instr = NOP;
        m.pc    = 32'h0;
        m.pc4   = 32'h0;
        m.mis   = 1'b0;
        m.cnt   = 32'h0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_valid"}, {31'b0, v}, 32'h0);
        chk({tag, "_instr"}, instr, NOP);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_pc4"}, pc4, 32'h0);
        chk({tag, "_mis"}, {31'b0, mis}, 32'h0);
        chk({tag, "_cnt"}, cnt, 32'h0);
    endtask

    // Drive one cycle, predict the post-edge state, compare after edge
    task automatic cyc(input string tag, input logic s, input logic f,
                       input logic r, input logic [31:0] rpc);
        exp_t e;
        stall    = s;
        flush    = f;
        redir    = r;
        redir_pc = rpc;
        if (r || f) begin
            m.v     = 1'b0;
            m.instr = NOP;
            m.mis   = 1'b0;
        end else if (!s) begin
            m.v     = 1'b1;
            m.instr = imem(m_pc);
            m.pc    = m_pc;
            m.pc4   = m_pc + 32'd4;
            m.mis   = m_mis;
            m.cnt   = m.cnt + 32'd1;
        end
        if (r) begin
            m_pc  = {rpc[31:2], 2'b00};
            m_mis = (rpc[1:0] != 2'b00);
        end else if (!s) begin
            m_pc  = m_pc + 32'd4;
            m_mis = 1'b0;
        end
        m.addr = m_pc;
        sb.push_back(m);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, "_addr"}, imem_addr, e.addr);
        chk({tag, "_valid"}, {31'b0, v}, {31'b0, e.v});
        chk({tag, "_instr"}, instr, e.instr);
        chk({tag, "_pc"}, pc, e.pc);
        chk({tag, "_pc4"}, pc4, e.pc4);
        chk({tag, "_mis"}, {31'b0, mis}, {31'b0, e.mis});
        chk({tag, "_cnt"}, cnt, e.cnt);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        @(negedge clk);
        rst = 1'b0;

        // Sequential fetch from RESET_PC
        cyc("seq1", 0, 0, 0, 0);
        chk("seq1_instr_d", instr, 32'h0050_0093);
        chk("seq1_pc4_d", pc4, 32'h4);
        cyc("seq2", 0, 0, 0, 0);
        chk("seq2_instr_d", instr, 32'h00A0_8113);
        chk("seq2_pc_d", pc, 32'h4);
        cyc("seq3", 0, 0, 0, 0);
        chk("seq3_addr_d", imem_addr, 32'hC);
        chk("seq3_cnt_d", cnt, 32'd3);
        cyc("seq4", 0, 0, 0, 0);
        cyc("seq5", 0, 0, 0, 0);
        chk("pre_stall_addr_d", imem_addr, 32'h14);

        // Load-use stall holds PC and IF/ID
        cyc("stall1", 1, 0, 0, 0);
        cyc("stall2", 1, 0, 0, 0);
        chk("stall_addr_d", imem_addr, 32'h14);
        chk("stall_cnt_d", cnt, 32'd5);
        cyc("unstall", 0, 0, 0, 0);
        chk("unstall_instr_d", instr, 32'h0030_2023);
        chk("unstall_pc_d", pc, 32'h14);

        // Redirect: bubble, then target capture
        cyc("redir", 0, 0, 1, 32'h1C);
        chk("redir_addr_d", imem_addr, 32'h1C);
        chk("redir_instr_d", instr, NOP);
        cyc("redir_cap", 0, 0, 0, 0);
        chk("redir_cap_d", instr, 32'h0002_8C63);

        // Misaligned redirect wins over stall
        cyc("mis_redir", 1, 0, 1, 32'h1D);
        chk("mis_addr_d", imem_addr, 32'h1C);
        cyc("mis_cap", 0, 0, 0, 0);
        chk("mis_cap_d", {31'b0, mis}, 32'h1);
        cyc("mis_next", 0, 0, 0, 0);
        chk("mis_next_d", {31'b0, mis}, 32'h0);

        // Flush alone advances PC; stall+flush holds PC
        cyc("to4", 0, 0, 1, 32'h4);
        cyc("flush", 0, 1, 0, 0);
        chk("flush_addr_d", imem_addr, 32'h8);
        chk("flush_valid_d", {31'b0, v}, 32'h0);
        cyc("stflush", 1, 1, 0, 0);
        chk("stflush_addr_d", imem_addr, 32'h8);
        cyc("refill", 0, 0, 0, 0);

        // PC wrap at top of address space
        cyc("to_top", 0, 0, 1, 32'hFFFF_FFFC);
        cyc("wrap", 0, 0, 0, 0);
        chk("wrap_addr_d", imem_addr, 32'h0);
        chk("wrap_pc4_d", pc4, 32'h0);
        chk("wrap_pc_d", pc, 32'hFFFF_FFFC);
        cyc("post_wrap", 0, 0, 0, 0);

        // Asynchronous reset mid-stall, away from any edge
        stall = 1'b1;
        redir = 1'b1;
        redir_pc = 32'h40;
        #2;
        rst = 1'b1;
        #1;
        chk_reset("arst");
        chk("sb_empty", sb.size(), 32'd0);
        stall = 1'b0;
        redir = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage RV32I pipeline.
- Owns the program counter and drives the combinational instruction_memory address.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles hazard stall, flush and redirect from EX (taken branch/jump), with a valid bit and misaligned-target flag per entry.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID when invalid.
- XLEN, 32, datapath width.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- stall_i  in  1  hold PC and IF/ID (load-use hazard from ID).
- flush_i  in  1  invalidate IF/ID entry next edge.
- redirect_i  in  1  EX taken branch/jump; load new PC.
- redirect_pc_i  in  32  redirect target.
- imem_addr_o  out  32  address to instruction_memory (= pc_q, combinational).
- imem_instr_i  in  32  instruction from instruction_memory, same cycle.
- if_id_valid_o  out  1  IF/ID entry holds a real instruction.
- if_id_instr_o  out  32  captured instruction, NOP_INSTR when invalid.
- if_id_pc_o  out  32  PC of captured instruction.
- if_id_pc_plus4_o  out  32  PC+4 of captured instruction.
- if_id_misalign_o  out  1  captured instruction came from a misaligned redirect target.
- fetch_count_o  out  32  count of valid instructions captured.

Behaviour:
- Reset (async, immediate on rst_i=1):
  - pc_q=RESET_PC, misalign_q=0, if_id_valid_o=0.
  - if_id_instr_o=NOP_INSTR, if_id_pc_o=0, if_id_pc_plus4_o=0, if_id_misalign_o=0, fetch_count_o=0.
  - Reset mid-stall or mid-redirect discards all state.
- imem_addr_o = pc_q always. Memory is combinational, so fetch latency is 1 cycle (PC to IF/ID).
- Per-edge priority for PC: redirect_i > stall_i > sequential.
  - redirect_i=1: pc_q <= {redirect_pc_i[31:2],2'b00}; misalign_q <= (redirect_pc_i[1:0]!=0).
  - stall_i=1 (no redirect): pc_q and misalign_q hold.
  - Otherwise: pc_q <= pc_q+4, modulo 2^32 (0xFFFF_FFFC wraps to 0); misalign_q <= 0.
- Per-edge priority for IF/ID: (redirect_i | flush_i) > stall_i > capture.
  - Flush: valid=0, instr=NOP_INSTR, pc and pc_plus4 hold, misalign=0.
  - Stall: all IF/ID fields hold.
  - Capture: valid=1, instr=imem_instr_i, pc=pc_q, pc_plus4=pc_q+4, misalign=misalign_q.
- Simultaneous events:
  - stall_i with flush_i: PC holds, IF/ID flushed.
  - stall_i with redirect_i: redirect wins for both PC and IF/ID.
  - flush_i alone: PC advances normally.
- fetch_count_o increments by 1 on each capture edge (not on stall/flush/redirect); wraps at 2^32.
- First capture occurs on the first edge after reset deassertion (entry for RESET_PC).
- Cycle after a redirect: imem_addr_o = aligned target; IF/ID shows a bubble.
- No combinational path from stall_i/flush_i/redirect_i to any output.

Decomposition:
- Shared package/header riscv_pkg: XLEN, NOP_INSTR, RESET_PC, INSTR_BYTES=4.
- One natural sub-module, if_id_reg: holds valid/instr/pc/pc_plus4/misalign with flush>stall>load priority.
- PC register, next-PC mux and fetch counter live in fetch_stage.
- Bench instantiates fetch_stage plus instruction_memory with the standard program image: 0x00=00500093, 0x04=00A08113, 0x14=00302023, 0x1C=00028C63.

Test Plan:
- Reset then release, no stall, 3 edges -> imem_addr_o 0x0→0x4→0x8→0xC; IF/ID after edge 1: valid=1, instr=00500093, pc=0x0, pc_plus4=0x4; after edge 2: instr=00A08113, pc=0x4; fetch_count_o=3.
- stall_i=1 for 2 cycles with pc_q=0x14 -> imem_addr_o stays 0x14, IF/ID unchanged, fetch_count_o unchanged; release -> IF/ID instr=00302023, pc=0x14.
- redirect_i=1, redirect_pc_i=0x1C -> next cycle imem_addr_o=0x1C, if_id_valid_o=0, instr=00000013; following edge IF/ID instr=00028C63, pc=0x1C.
- redirect_pc_i=0x1D with stall_i=1 same cycle -> pc_q=0x1C (redirect wins), IF/ID flushed; next capture has if_id_misalign_o=1; capture after that has if_id_misalign_o=0.
- flush_i=1 alone at pc_q=0x4 -> PC advances to 0x8, IF/ID valid=0 and instr=NOP; fetch_count_o not incremented.
- Force pc_q=0xFFFF_FFFC via redirect, then 1 free edge -> imem_addr_o=0x0, if_id_pc_plus4_o=0x0. Assert rst_i mid-sequence -> all outputs return to reset values without a clock edge.
